// File: rtl/rule_accum.sv
// Rule-aggregation stage ahead of the defuzzifier: accumulates Σw and Σ(w·g) over a
// frame of fired rules, then presents the sums with a one-cycle start pulse.
module rule_accum #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rule_valid,
    output logic             rule_ready,
    input  logic [15:0]      rule_w,
    input  logic [15:0]      rule_g,
    input  logic             rule_last,
    output logic [23:0]      S_w,
    output logic [31:0]      S_wg,
    output logic             start,
    output logic [CNT_W-1:0] n_rules,
    output logic             sat
);

    typedef enum logic [1:0] {IDLE, ACC, FLUSH, EMIT} state_t;

    localparam logic [15:0] Q_ONE = 16'h8000;

    state_t             state, state_nxt;
    logic               accepting;
    logic               xfer;

    logic [15:0]        w_c, g_c;
    logic               clamp_hit;

    logic               s1_valid;
    logic [15:0]        s1_w;
    logic [31:0]        s1_p;

    logic [23:0]        acc_w, acc_w_add;
    logic [31:0]        acc_wg, acc_wg_add;
    logic [24:0]        sum_w;
    logic [32:0]        sum_wg;
    logic               add_sat;
    logic               sat_flag;
    logic [CNT_W-1:0]   cnt;

    // Ready is forced low while reset is held so no beat is taken during reset.
    assign rule_ready = rst_n & accepting;
    assign xfer       = rule_valid & rule_ready;

    always_comb begin
        state_nxt = state;
        accepting = 1'b0;
        start     = 1'b0;
        case (state)
            IDLE: begin
                accepting = 1'b1;
                if (xfer) state_nxt = rule_last ? FLUSH : ACC;
            end
            ACC: begin
                accepting = 1'b1;
                if (xfer && rule_last) state_nxt = FLUSH;
            end
            FLUSH: state_nxt = EMIT;
            EMIT: begin
                start     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_c       = (rule_w > Q_ONE) ? Q_ONE : rule_w;
        g_c       = (rule_g > Q_ONE) ? Q_ONE : rule_g;
        clamp_hit = (rule_w > Q_ONE) || (rule_g > Q_ONE);
    end

    // Stage-2 adders; a carry pins the accumulator at all-ones, and since adding to
    // all-ones either keeps it or carries again, the saturation sticks for the frame.
    always_comb begin
        sum_w      = {1'b0, acc_w} + {9'b0, s1_w};
        sum_wg     = {1'b0, acc_wg} + {1'b0, s1_p};
        acc_w_add  = acc_w;
        acc_wg_add = acc_wg;
        add_sat    = 1'b0;
        if (s1_valid) begin
            acc_w_add  = sum_w[24]  ? {24{1'b1}} : sum_w[23:0];
            acc_wg_add = sum_wg[32] ? {32{1'b1}} : sum_wg[31:0];
            add_sat    = sum_w[24] | sum_wg[32];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            s1_valid <= 1'b0;
            s1_w     <= '0;
            s1_p     <= '0;
            acc_w    <= '0;
            acc_wg   <= '0;
            sat_flag <= 1'b0;
            cnt      <= '0;
            S_w      <= '0;
            S_wg     <= '0;
            n_rules  <= '0;
            sat      <= 1'b0;
        end else begin
            state    <= state_nxt;
            s1_valid <= xfer;
            if (xfer) begin
                s1_w <= w_c;
                s1_p <= {16'b0, w_c} * {16'b0, g_c};
            end

            if (state == EMIT) begin
                acc_w    <= '0;
                acc_wg   <= '0;
                sat_flag <= 1'b0;
                cnt      <= '0;
            end else begin
                acc_w    <= acc_w_add;
                acc_wg   <= acc_wg_add;
                sat_flag <= sat_flag | add_sat | (xfer & clamp_hit);
                if (xfer && cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
            end

            // The last beat's add lands in FLUSH, so outputs take the post-add values.
            if (state == FLUSH) begin
                S_w     <= acc_w_add;
                S_wg    <= acc_wg_add;
                n_rules <= cnt;
                sat     <= sat_flag | add_sat;
            end
        end
    end

endmodule

// File: tb/tb_rule_accum.sv
// Self-checking bench for rule_accum: a frame model pushes expected sums to a
// scoreboard queue, and a monitor pops and compares on every start pulse.
module tb_rule_accum;

    localparam int CNT_W = 10;

    typedef struct {
        logic [23:0] s_w;
        logic [31:0] s_wg;
        int          n;
        logic        sat;
        int          last_cyc;
    } frame_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             rule_valid;
    logic             rule_ready;
    logic [15:0]      rule_w;
    logic [15:0]      rule_g;
    logic             rule_last;
    logic [23:0]      S_w;
    logic [31:0]      S_wg;
    logic             start;
    logic [CNT_W-1:0] n_rules;
    logic             sat;

    int testsRun    = 0;
    int testsFailed = 0;
    int cyc         = 0;

    frame_t expQ[$];

    longint mSumW, mSumWG;
    int     mN;
    bit     mClamp;

    rule_accum #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .rule_valid(rule_valid), .rule_ready(rule_ready),
        .rule_w(rule_w), .rule_g(rule_g), .rule_last(rule_last),
        .S_w(S_w), .S_wg(S_wg), .start(start), .n_rules(n_rules), .sat(sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic clearModel();
        mSumW  = 0;
        mSumWG = 0;
        mN     = 0;
        mClamp = 0;
    endtask

    // Drive one beat and hold it until the DUT accepts; returns the accept cycle.
    task automatic applyStimulus(input logic [15:0] w, input logic [15:0] g, input logic last,
                                 output int accCyc);
        bit     accepted;
        longint cw, cg;
        frame_t f;
        @(negedge clk);
        rule_valid = 1'b1;
        rule_w     = w;
        rule_g     = g;
        rule_last  = last;
        accepted   = 0;
        accCyc     = -1;
        for (int i = 0; i < 40; i++) begin
            if (rule_ready) begin
                accCyc   = cyc;
                accepted = 1;
                break;
            end
            @(negedge clk);
        end
        if (!accepted) begin
            checkOutput("accept_timeout", 64'd0, 64'd1);
            rule_valid = 1'b0;
            return;
        end
        @(posedge clk);
        cw = (w > 16'h8000) ? 64'h8000 : longint'(w);
        cg = (g > 16'h8000) ? 64'h8000 : longint'(g);
        if (w > 16'h8000 || g > 16'h8000) mClamp = 1;
        mSumW  += cw;
        mSumWG += cw * cg;
        mN++;
        if (last) begin
            f.s_w      = (mSumW > 64'hFFFFFF) ? 24'hFFFFFF : mSumW[23:0];
            f.s_wg     = (mSumWG > 64'hFFFFFFFF) ? 32'hFFFFFFFF : mSumWG[31:0];
            f.n        = (mN > 1023) ? 1023 : mN;
            f.sat      = mClamp || (mSumW > 64'hFFFFFF) || (mSumWG > 64'hFFFFFFFF);
            f.last_cyc = accCyc;
            expQ.push_back(f);
            clearModel();
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rule_valid = 1'b0;
        end
    endtask

    // Monitor: compares every emitted frame against the head of the scoreboard.
    bit prevStart = 0;
    bit prevReady = 0;
    bit checkIdle = 0;
    always @(negedge clk) begin
        frame_t f;
        if (checkIdle) begin
            checkOutput("ready_after_emit", {63'd0, rule_ready}, 64'd1);
            checkIdle = 0;
        end
        if (start) begin
            checkOutput("start_single_pulse", {63'd0, prevStart}, 64'd0);
            checkOutput("ready_in_emit", {63'd0, rule_ready}, 64'd0);
            checkOutput("ready_in_flush", {63'd0, prevReady}, 64'd0);
            if (expQ.size() == 0) begin
                checkOutput("unexpected_start", 64'd1, 64'd0);
            end else begin
                f = expQ.pop_front();
                checkOutput("S_w", {40'd0, S_w}, {40'd0, f.s_w});
                checkOutput("S_wg", {32'd0, S_wg}, {32'd0, f.s_wg});
                checkOutput("n_rules", {54'd0, n_rules}, 64'(f.n));
                checkOutput("sat", {63'd0, sat}, {63'd0, f.sat});
                checkOutput("start_latency", 64'(cyc - f.last_cyc), 64'd2);
                checkIdle = 1;
            end
        end
        prevStart = start;
        prevReady = rule_ready;
    end

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_S_w"}, {40'd0, S_w}, 64'd0);
        checkOutput({tag, "_S_wg"}, {32'd0, S_wg}, 64'd0);
        checkOutput({tag, "_n_rules"}, {54'd0, n_rules}, 64'd0);
        checkOutput({tag, "_sat"}, {63'd0, sat}, 64'd0);
        checkOutput({tag, "_start"}, {63'd0, start}, 64'd0);
        checkOutput({tag, "_ready_low"}, {63'd0, rule_ready}, 64'd0);
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst_n      = 1'b0;
        rule_valid = 1'b0;
        @(negedge clk);
        checkResetOutputs("reset");
        rst_n = 1'b1;
        #1;
        checkOutput("ready_after_reset", {63'd0, rule_ready}, 64'd1);
        clearModel();
    endtask

    initial begin
        int a, b, held;
        int nb;
        rst_n      = 1'b0;
        rule_valid = 1'b0;
        rule_w     = '0;
        rule_g     = '0;
        rule_last  = 1'b0;
        clearModel();
        repeat (2) @(negedge clk);
        applyReset();

        // Single full-weight beat.
        applyStimulus(16'h8000, 16'h4000, 1'b1, a);
        idleCycles(4);

        // Three back-to-back beats.
        applyStimulus(16'h4000, 16'h8000, 1'b0, a);
        applyStimulus(16'h2000, 16'h0000, 1'b0, a);
        applyStimulus(16'h2000, 16'h8000, 1'b1, a);
        idleCycles(4);

        // Product accumulator saturation, then a clean frame.
        for (int i = 0; i < 5; i++) applyStimulus(16'h8000, 16'h8000, i == 4, a);
        applyStimulus(16'h8000, 16'h8000, 1'b1, a);
        idleCycles(4);

        // Input clamp.
        applyStimulus(16'hFFFF, 16'h8000, 1'b1, a);
        idleCycles(4);

        // Gaps inside a frame, then a beat held through FLUSH/EMIT.
        applyStimulus(16'h1000, 16'h2000, 1'b0, a);
        idleCycles(3);
        applyStimulus(16'h3000, 16'h4000, 1'b1, b);
        applyStimulus(16'h0100, 16'h0200, 1'b1, held);
        checkOutput("held_beat_cycle", 64'(held - b), 64'd3);
        idleCycles(4);

        // Reset mid-frame discards the partial frame.
        applyStimulus(16'h7000, 16'h7000, 1'b0, a);
        applyStimulus(16'h6000, 16'h6000, 1'b0, a);
        applyReset();
        applyStimulus(16'h0000, 16'h8000, 1'b1, a);
        idleCycles(3);
        applyStimulus(16'h1234, 16'h8000, 1'b1, a);
        idleCycles(4);

        // Random frames, occasionally out of range to exercise the clamp.
        for (int f = 0; f < 6; f++) begin
            nb = $urandom_range(1, 6);
            for (int i = 0; i < nb; i++) begin
                applyStimulus(16'($urandom_range(0, 16'h9000)), 16'($urandom_range(0, 16'h9000)),
                              i == nb - 1, a);
                if ($urandom_range(0, 3) == 0) idleCycles(1);
            end
        end

        for (int i = 0; i < 50 && expQ.size() != 0; i++) idleCycles(1);
        checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
        idleCycles(3);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
